// File: rtl/sram_like_data_responder_pkg.sv
// Shared definitions for the SRAM-like data responder.
//   DATA_W       : bus data width
//   size_e       : access size encodings carried on the size port
//   wstrb_legal  : checks that a store's byte enables match its size/alignment
package sram_like_data_responder_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  function automatic logic wstrb_legal(input logic [1:0] size,
                                       input logic [1:0] addr_lo,
                                       input logic [3:0] wstrb);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_B:  ok = (wstrb == (4'b0001 << addr_lo));
      SIZE_H:  ok = !addr_lo[0] && (wstrb == (4'b0011 << addr_lo));
      SIZE_W:  ok = (addr_lo == 2'b00) && (wstrb == 4'b1111);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sram_like_data_responder_resp_queue.sv
// sram_resp_queue: in-order pending-response FIFO with a per-entry latency
// counter. Each pushed entry starts at RESP_LAT-1 and counts down to 0
// (saturating); the head may be popped once its counter reaches 0.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push             write a new entry {push_is_wr, push_data}
//   pop              retire the head entry
//   full, empty      occupancy flags
//   head_is_wr       head entry is a store response
//   head_data        head entry data
//   head_lat_zero    head entry latency counter has expired
module sram_resp_queue
  import sram_like_data_responder_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESP_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              push_is_wr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              head_is_wr,
  output logic [DATA_W-1:0] head_data,
  output logic              head_lat_zero
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RESP_LAT - 1);

  logic              entry_is_wr [DEPTH];
  logic [DATA_W-1:0] entry_data  [DEPTH];
  logic [LAT_W-1:0]  entry_lat   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Counters of every slot tick down each cycle; stale slots are never read
  // because head validity is qualified by empty.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        entry_is_wr[i] <= push_is_wr;
        entry_data[i]  <= push_data;
        entry_lat[i]   <= LAT_INIT;
      end else if (entry_lat[i] != '0) begin
        entry_lat[i] <= entry_lat[i] - 1'b1;
      end
    end
  end

  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign head_is_wr    = entry_is_wr[rd_ptr];
  assign head_data     = entry_data[rd_ptr];
  assign head_lat_zero = (entry_lat[rd_ptr] == '0);

endmodule

// File: rtl/sram_like_data_responder.sv
// sram_like_data_responder: responder end of the data SRAM-like bus.
// Requests are accepted into an in-order pending queue; stores write the
// word-addressed RAM and loads read it in the handshake cycle, and one
// response (data_ok pulse) is returned per request after RESP_LAT cycles.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   req          request valid
//   wr           1 = store, 0 = load
//   size         0 byte, 1 half, 2 word (checked only, not used by datapath)
//   wstrb        byte-lane write enables for stores
//   addr         byte address; word index = addr[MEM_AW+1:2]
//   wdata        lane-replicated store data
//   addr_ok      request accepted when req & addr_ok
//   data_ok      response for the oldest pending request
//   rdata        aligned load word on data_ok, 0 otherwise and for stores
// Optional build macro SRAM_RESP_RAND_DELAY_EN: a 16-bit LFSR randomly gates
// addr_ok and data_ok to exercise requester stall paths.
module sram_like_data_responder
  import sram_like_data_responder_pkg::*;
#(
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned PEND_DEPTH = 4,
  parameter int unsigned RESP_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [DATA_W-1:0] mem [2**MEM_AW];

  logic              gate_a;
  logic              gate_d;
  logic              handshake;
  logic [MEM_AW-1:0] word_idx;
  logic              q_full;
  logic              q_empty;
  logic              head_is_wr;
  logic [DATA_W-1:0] head_data;
  logic              head_lat_zero;
  logic              unused_addr_hi;

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign gate_a = lfsr[0];
  assign gate_d = lfsr[1];
`else
  assign gate_a = 1'b1;
  assign gate_d = 1'b1;
`endif

  assign word_idx       = addr[MEM_AW+1:2];
  assign unused_addr_hi = ^addr[31:MEM_AW+2];

  // Full blocks acceptance even when the head retires this cycle.
  assign addr_ok   = ~reset & ~q_full & gate_a;
  assign handshake = req & addr_ok;
  assign data_ok   = ~reset & ~q_empty & head_lat_zero & gate_d;
  assign rdata     = (data_ok && !head_is_wr) ? head_data : '0;

  always_ff @(posedge clk) begin
    if (handshake && wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  sram_resp_queue #(
    .DEPTH    (PEND_DEPTH),
    .RESP_LAT (RESP_LAT)
  ) u_queue (
    .clk           (clk),
    .reset         (reset),
    .push          (handshake),
    .push_is_wr    (wr),
    .push_data     (mem[word_idx]),
    .pop           (data_ok),
    .full          (q_full),
    .empty         (q_empty),
    .head_is_wr    (head_is_wr),
    .head_data     (head_data),
    .head_lat_zero (head_lat_zero)
  );

  // Protocol checks on the requester side.
  logic        held_pending;
  logic        held_wr;
  logic [1:0]  held_size;
  logic [3:0]  held_wstrb;
  logic [31:0] held_addr;
  logic [31:0] held_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_pending <= 1'b0;
    end else begin
      held_pending <= req & ~addr_ok;
      held_wr      <= wr;
      held_size    <= size;
      held_wstrb   <= wstrb;
      held_addr    <= addr;
      held_wdata   <= wdata;
      if (handshake && wr) begin
        assert (wstrb != 4'b0000)
          else $error("store accepted with empty wstrb at addr %h", addr);
        assert (wstrb_legal(size, addr[1:0], wstrb))
          else $error("wstrb %b inconsistent with size %0d addr %h", wstrb, size, addr);
      end
      if (held_pending && req) begin
        assert ({wr, size, wstrb, addr, wdata} ==
                {held_wr, held_size, held_wstrb, held_addr, held_wdata})
          else $error("request attributes changed while waiting for addr_ok");
      end
    end
  end

endmodule
